fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard unit for the pipelined MIPS core, the successor to the fixed two-stage forwarding logic. It tracks in-flight register writers in an internal stage tracker, fed by the instruction leaving ID, instead of taking per-stage register fields as inputs. From that state it generates forwarding selects for N source operands in EX, branch-operand forwarding selects in ID, and load-use / branch-use stall requests. It sits beside the ID stage and drives the EX operand muxes, the ID branch-comparator muxes, and the IF/ID hold logic.

---
 rtl/fwd_hazard_unit.sv | 83 ++++++++
 tb/tb_fwd_hazard_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: tracks in-flight writers and drives EX/ID forwarding selects and load/branch-use stalls
module fwd_hazard_unit #(
  parameter int AW = 5,
  parameter int NSRC = 2,
  parameter int DEPTH = 3,
  parameter int LOAD_RDY = 2,
  localparam int SELW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_rs,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_regwrite,
  input  logic                 id_is_load,
  input  logic                 id_is_branch,
  input  logic                 freeze,
  input  logic                 flush,
  output logic                 hazard_stall,
  output logic [NSRC*SELW-1:0] ex_fwd_sel,
  output logic [NSRC*SELW-1:0] id_fwd_sel,
  output logic [15:0]          stall_count
);
  logic [DEPTH-1:0] v_q, v_d, wr_q, wr_d, ld_q, ld_d;
  logic [DEPTH-1:0][AW-1:0] rd_q, rd_d;
  logic [NSRC*AW-1:0] src_q, src_d;
  logic [NSRC-1:0] used_q, used_d, stall_j;
  logic [NSRC-1:0][SELW-1:0] sel_j;
  logic [15:0] stall_count_q, stall_count_d;
  always_comb begin
    stall_j = '0;
    sel_j = '0;
    ex_fwd_sel = '0;
    id_fwd_sel = '0;
    for (int j = 0; j < NSRC; j++)
      for (int s = DEPTH - 1; s >= 0; s--)
        if (v_q[s] && wr_q[s] && rd_q[s] == id_rs[j*AW +: AW] && id_rs[j*AW +: AW] != '0) begin
          sel_j[j] = SELW'(s);
          stall_j[j] = id_src_used[j] && (id_is_branch ? (s < (ld_q[s] ? LOAD_RDY : 1))
                                                       : (s + 1 < (ld_q[s] ? LOAD_RDY : 1)));
        end
    hazard_stall = id_valid && !flush && |stall_j;
    for (int j = 0; j < NSRC; j++)
      id_fwd_sel[j*SELW +: SELW] = (id_is_branch && id_valid && id_src_used[j] && !stall_j[j]) ? sel_j[j] : '0;
    for (int k = 0; k < NSRC; k++)
      for (int s = DEPTH - 1; s >= 1; s--)
        if (v_q[0] && used_q[k] && v_q[s] && wr_q[s] && rd_q[s] == src_q[k*AW +: AW] && src_q[k*AW +: AW] != '0)
          ex_fwd_sel[k*SELW +: SELW] = SELW'(s);
  end
  always_comb begin
    v_d = v_q;
    wr_d = wr_q;
    ld_d = ld_q;
    rd_d = rd_q;
    src_d = src_q;
    used_d = used_q;
    if (!freeze) begin
      v_d = {v_q[DEPTH-2:0], id_valid && !hazard_stall && !flush};
      wr_d = {wr_q[DEPTH-2:0], id_regwrite};
      ld_d = {ld_q[DEPTH-2:0], id_is_load};
      rd_d = {rd_q[DEPTH-2:0], id_rd};
      src_d = id_rs;
      used_d = id_src_used;
    end
    stall_count_d = stall_count_q + 16'(hazard_stall && !freeze && stall_count_q != 16'hFFFF);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q <= '0;
      stall_count_q <= '0;
    end else begin
      v_q <= v_d;
      stall_count_q <= stall_count_d;
    end
    wr_q <= wr_d;
    ld_q <= ld_d;
    rd_q <= rd_d;
    src_q <= src_d;
    used_q <= used_d;
  end
  assign stall_count = stall_count_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of stalls, forwarding selects and stall counting
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic reset, id_valid, id_regwrite, id_is_load, id_is_branch, freeze, flush;
  logic [9:0] id_rs;
  logic [1:0] id_src_used;
  logic [4:0] id_rd;
  logic hazard_stall;
  logic [3:0] ex_fwd_sel, id_fwd_sel;
  logic [15:0] stall_count;
  int checks = 0;
  int errors = 0;
  fwd_hazard_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_src_used(id_src_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load), .id_is_branch(id_is_branch),
    .freeze(freeze), .flush(flush), .hazard_stall(hazard_stall), .ex_fwd_sel(ex_fwd_sel),
    .id_fwd_sel(id_fwd_sel), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic id_set(input logic v, input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] u,
                        input logic [4:0] rd, input logic w, input logic ld, input logic br);
    id_valid = v;
    id_rs = {r1, r0};
    id_src_used = u;
    id_rd = rd;
    id_regwrite = w;
    id_is_load = ld;
    id_is_branch = br;
    #1;
  endtask
  task automatic drain;
    id_set(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask
  initial begin
    reset = 1;
    freeze = 0;
    flush = 0;
    id_set(1, 5, 0, 2'b01, 5, 1, 1, 0);
    repeat (2) tick();
    chk("rst_stall", hazard_stall, 0);
    chk("rst_ex", ex_fwd_sel, 0);
    chk("rst_id", id_fwd_sel, 0);
    chk("rst_cnt", stall_count, 0);
    reset = 0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rel_cnt", stall_count, 0);
    id_set(1, 1, 2, 2'b11, 3, 1, 0, 0);
    chk("alu_a_stall", hazard_stall, 0);
    tick();
    id_set(1, 3, 3, 2'b11, 4, 1, 0, 0);
    chk("alu_b_stall", hazard_stall, 0);
    tick();
    id_set(1, 3, 3, 2'b11, 10, 1, 0, 0);
    chk("alu_ex1", ex_fwd_sel, 4'b0101);
    chk("alu_c_stall", hazard_stall, 0);
    tick();
    id_set(0, 0, 0, 0, 0, 0, 0, 0);
    chk("alu_ex2", ex_fwd_sel, 4'b1010);
    drain();
    id_set(1, 1, 0, 2'b01, 5, 1, 1, 0);
    tick();
    id_set(1, 5, 0, 2'b11, 6, 1, 0, 0);
    chk("lu_stall1", hazard_stall, 1);
    tick();
    chk("lu_stall2", hazard_stall, 0);
    chk("lu_cnt", stall_count, 1);
    tick();
    id_set(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_ex", ex_fwd_sel, 4'b0010);
    drain();
    id_set(1, 0, 0, 2'b00, 7, 1, 1, 0);
    tick();
    id_set(1, 7, 0, 2'b11, 0, 0, 0, 1);
    chk("lb_stall1", hazard_stall, 1);
    chk("lb_id1", id_fwd_sel, 0);
    tick();
    chk("lb_stall2", hazard_stall, 1);
    tick();
    chk("lb_stall3", hazard_stall, 0);
    chk("lb_id", id_fwd_sel, 4'b0010);
    chk("lb_cnt", stall_count, 3);
    drain();
    id_set(1, 0, 0, 2'b00, 7, 1, 0, 0);
    tick();
    id_set(1, 7, 0, 2'b11, 0, 0, 0, 1);
    chk("ab_stall1", hazard_stall, 1);
    tick();
    chk("ab_stall2", hazard_stall, 0);
    chk("ab_id", id_fwd_sel, 4'b0001);
    chk("ab_cnt", stall_count, 4);
    drain();
    id_set(1, 0, 0, 2'b00, 0, 1, 1, 0);
    tick();
    id_set(1, 0, 0, 2'b11, 11, 1, 0, 0);
    chk("r0_stall", hazard_stall, 0);
    tick();
    chk("r0_ex", ex_fwd_sel, 0);
    drain();
    id_set(1, 1, 2, 2'b11, 8, 1, 0, 0);
    tick();
    tick();
    id_set(1, 8, 8, 2'b11, 12, 0, 0, 0);
    chk("yw_stall", hazard_stall, 0);
    tick();
    chk("yw_ex", ex_fwd_sel, 4'b0101);
    id_set(1, 8, 8, 2'b11, 0, 0, 0, 1);
    chk("yw_br_stall", hazard_stall, 0);
    chk("yw_id", id_fwd_sel, 4'b0101);
    drain();
    id_set(1, 1, 0, 2'b01, 5, 1, 1, 0);
    tick();
    id_set(1, 5, 0, 2'b01, 6, 1, 0, 0);
    chk("fz_stall0", hazard_stall, 1);
    freeze = 1;
    #1;
    chk("fz_stall1", hazard_stall, 1);
    tick();
    chk("fz_stall2", hazard_stall, 1);
    chk("fz_cnt1", stall_count, 4);
    tick();
    chk("fz_cnt2", stall_count, 4);
    freeze = 0;
    #1;
    tick();
    chk("fz_cnt3", stall_count, 5);
    chk("fz_stall3", hazard_stall, 0);
    tick();
    chk("fz_ex", ex_fwd_sel, 4'b0010);
    drain();
    id_set(1, 1, 0, 2'b01, 5, 1, 1, 0);
    tick();
    flush = 1;
    id_set(1, 5, 0, 2'b01, 6, 1, 0, 0);
    chk("fl_stall", hazard_stall, 0);
    tick();
    flush = 0;
    #1;
    chk("fl_ex", ex_fwd_sel, 0);
    chk("fl_cnt", stall_count, 5);
    drain();
    id_set(1, 1, 0, 2'b01, 5, 1, 1, 0);
    tick();
    id_set(1, 5, 0, 2'b01, 6, 1, 0, 0);
    chk("rm_stall1", hazard_stall, 1);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("rm_stall2", hazard_stall, 0);
    chk("rm_cnt", stall_count, 0);
    chk("rm_ex", ex_fwd_sel, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
